// File: rtl/prog_ctrl_pkg.sv
// Shared encodings and constants for the program load / dump sequencer.
package prog_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int          BYTE_LANES = 4;
  localparam logic [31:0] DEF_END_PC = 32'h78;
endpackage

// File: rtl/byte_packer.sv
// Little-endian 8-to-32 assembler: byte k of a word lands in bits [8k+7:8k];
// out_valid pulses for one cycle with the completed word.
module byte_packer
  import prog_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [1:0]  lane,
  output logic        out_valid,
  output logic [31:0] out_data
);
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    vld_d  = 1'b0;
    word_d = word_q;
    if (clr) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (in_valid) begin
      if (lane_q == 2'(BYTE_LANES - 1)) begin
        word_d = {in_data, acc_q};
        vld_d  = 1'b1;
        lane_d = '0;
      end else begin
        acc_d[int'(lane_q)*8 +: 8] = in_data;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign lane      = lane_q;
  assign out_valid = vld_q;
  assign out_data  = word_q;
endmodule

// File: rtl/prog_load_dump_ctrl.sv
// Load program bytes into imem, run the core to END_PC, then dump a dmem window.
// Define LOADER_WDOG_EN to add a RUN-phase watchdog that forces the dump with timeout = 1.
module prog_load_dump_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter logic [31:0] END_PC      = DEF_END_PC,
  parameter int          LOAD_WORDS  = 64,
  parameter int          DUMP_BASE   = 32,
  parameter int          DUMP_WORDS  = 96,
`ifdef LOADER_WDOG_EN
  parameter int          WDOG_CYCLES = 4096,
`endif
  parameter int          ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       cpu_pc,
  output logic              dmem_re,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_rdata,
  output logic              dmp_valid,
  output logic [31:0]       dmp_data,
  input  logic              dmp_ready,
  output logic              timeout,
  output logic              done
);
  localparam int WCW = $clog2(LOAD_WORDS + 1);
  localparam int IXW = $clog2(DUMP_WORDS + 1);

  state_e            state_q, state_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic              dmem_re_q, dmem_re_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [IXW-1:0]    idx_q, idx_d;
  logic              dmp_valid_q, dmp_valid_d;
  logic [31:0]       dmp_data_q, dmp_data_d;
  logic              done_q, done_d;
  logic              pk_clr, pk_vld;
  logic [1:0]        pk_lane;
  logic              accept, rd_load;
`ifdef LOADER_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  assign accept  = ld_valid & ld_ready_q;
  // dmem_rdata follows dmem_addr_q combinationally, so a fetch is just a capture
  assign rd_load = dmem_re_q & (~dmp_valid_q | dmp_ready);

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (pk_clr),
    .in_valid (accept),
    .in_data  (ld_data),
    .lane     (pk_lane),
    .out_valid(pk_vld),
    .out_data (imem_wdata)
  );

  always_comb begin
    state_d     = state_q;
    ld_ready_d  = ld_ready_q;
    cpu_reset_d = cpu_reset_q;
    imem_addr_d = imem_addr_q;
    word_cnt_d  = word_cnt_q;
    dmem_re_d   = dmem_re_q;
    dmem_addr_d = dmem_addr_q;
    idx_d       = idx_q;
    dmp_valid_d = dmp_valid_q;
    dmp_data_d  = dmp_data_q;
    done_d      = done_q;
    pk_clr      = 1'b0;
`ifdef LOADER_WDOG_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          ld_ready_d  = 1'b1;
          cpu_reset_d = 1'b1;
          imem_addr_d = '0;
          word_cnt_d  = '0;
          dmem_addr_d = '0;
          idx_d       = '0;
          done_d      = 1'b0;
          pk_clr      = 1'b1;
`ifdef LOADER_WDOG_EN
          wd_cnt_d    = '0;
          timeout_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept && pk_lane == 2'd3) begin
          imem_addr_d = ADDR_W'(word_cnt_q);
          word_cnt_d  = word_cnt_q + 1'b1;
          if (word_cnt_q == WCW'(LOAD_WORDS - 1)) ld_ready_d = 1'b0;
        end
        // release the core only after the final word has been written
        if (pk_vld && word_cnt_q == WCW'(LOAD_WORDS)) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
        end
      end
      ST_RUN: begin
`ifdef LOADER_WDOG_EN
        wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        if (cpu_pc == END_PC) begin
          state_d = ST_DUMP;
`ifdef LOADER_WDOG_EN
        end else if (wd_cnt_q == WDW'(WDOG_CYCLES - 1)) begin
          state_d   = ST_DUMP;
          timeout_d = 1'b1;
`endif
        end
        if (state_d == ST_DUMP) begin
          cpu_reset_d = 1'b1;
          dmem_re_d   = 1'b1;
          dmem_addr_d = ADDR_W'(DUMP_BASE);
          idx_d       = '0;
        end
      end
      ST_DUMP: begin
        if (dmp_valid_q && dmp_ready) dmp_valid_d = 1'b0;
        if (rd_load) begin
          dmp_valid_d = 1'b1;
          dmp_data_d  = dmem_rdata;
          idx_d       = idx_q + 1'b1;
          dmem_addr_d = dmem_addr_q + 1'b1;
          dmem_re_d   = (idx_q != IXW'(DUMP_WORDS - 1));
        end
        if (dmp_valid_q && dmp_ready && !dmem_re_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ld_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      imem_addr_q <= '0;
      word_cnt_q  <= '0;
      dmem_re_q   <= 1'b0;
      dmem_addr_q <= '0;
      idx_q       <= '0;
      dmp_valid_q <= 1'b0;
      dmp_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef LOADER_WDOG_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ld_ready_q  <= ld_ready_d;
      cpu_reset_q <= cpu_reset_d;
      imem_addr_q <= imem_addr_d;
      word_cnt_q  <= word_cnt_d;
      dmem_re_q   <= dmem_re_d;
      dmem_addr_q <= dmem_addr_d;
      idx_q       <= idx_d;
      dmp_valid_q <= dmp_valid_d;
      dmp_data_q  <= dmp_data_d;
      done_q      <= done_d;
`ifdef LOADER_WDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign ld_ready  = ld_ready_q;
  assign imem_we   = pk_vld;
  assign imem_addr = imem_addr_q;
  assign cpu_reset = cpu_reset_q;
  assign dmem_re   = dmem_re_q;
  assign dmem_addr = dmem_addr_q;
  assign dmp_valid = dmp_valid_q;
  assign dmp_data  = dmp_data_q;
  assign done      = done_q;
`ifdef LOADER_WDOG_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_prog_load_dump_ctrl.sv
// Scoreboard bench: stimulus pushes expected imem writes / dump words, a negedge monitor pops and compares.
module tb_prog_load_dump_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, ld_valid, dmp_ready;
  logic [7:0]  ld_data;
  logic [31:0] cpu_pc;
  logic        ld_ready, imem_we, cpu_reset, dmem_re, dmp_valid, timeout, done;
  logic [7:0]  imem_addr, dmem_addr;
  logic [31:0] imem_wdata, dmem_rdata, dmp_data;

  logic [31:0] dmem [256];
  assign dmem_rdata = dmem[dmem_addr];

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] imem_q [$];
  logic [31:0] dmp_q  [$];
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic [7:0]  prog [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic        rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  prog_load_dump_ctrl #(
    .END_PC(32'h78), .LOAD_WORDS(2), .DUMP_BASE(32), .DUMP_WORDS(96),
`ifdef LOADER_WDOG_EN
    .WDOG_CYCLES(16),
`endif
    .ADDR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .dmem_re(dmem_re), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .dmp_valid(dmp_valid), .dmp_data(dmp_data), .dmp_ready(dmp_ready),
    .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_data  = b;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic push_prog();
    imem_q.push_back({8'd0, 32'h12345678});
    imem_q.push_back({8'd1, 32'hDEADBEEF});
  endtask

  task automatic push_dump();
    for (int k = 0; k < 96; k++) dmp_q.push_back(32'hC0DE0000 | 32'(32 + k));
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (cpu_reset !== 1'b0 && n < 20) begin tick(); n++; end
    chk(name, {31'd0, cpu_reset}, 32'd0);
  endtask

  task automatic drain_dump(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 2000) begin
      dmp_ready = 1'b1;
      tick();
      cycles++;
    end
    dmp_ready = 1'b0;
  endtask

  // monitor: every imem write and dump handshake must match the head of its queue
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_vec++;
      if (imem_q.size() == 0) begin
        n_err++;
        $display("FAIL imem_unexpected: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = imem_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_err++;
          $display("FAIL imem_write: got %h/%h expected %h/%h", imem_addr, imem_wdata, e[39:32], e[31:0]);
        end
      end
    end
    if (stall_prev) begin
      n_vec++;
      if (dmp_valid !== 1'b1 || dmp_data !== stall_data) begin
        n_err++;
        $display("FAIL dump_stall_hold: got v=%b %h expected v=1 %h", dmp_valid, dmp_data, stall_data);
      end
    end
    if (dmp_valid === 1'b1 && dmp_ready === 1'b1) begin
      n_vec++;
      if (dmp_q.size() == 0) begin
        n_err++;
        $display("FAIL dump_unexpected: got %h expected no word", dmp_data);
      end else begin
        logic [31:0] e;
        e = dmp_q.pop_front();
        if (dmp_data !== e) begin
          n_err++;
          $display("FAIL dump_word: got %h expected %h", dmp_data, e);
        end
      end
    end
    stall_prev = (dmp_valid === 1'b1) && (dmp_ready !== 1'b1);
    stall_data = dmp_data;
  end

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) dmem[i] = 32'hC0DE0000 | 32'(i);
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; dmp_ready = 1'b0; cpu_pc = '0;
    repeat (3) tick();
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
    chk("rst_imem_we",   {31'd0, imem_we},   32'd0);
    chk("rst_dmem_re",   {31'd0, dmem_re},   32'd0);
    chk("rst_dmp_valid", {31'd0, dmp_valid}, 32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_timeout",   {31'd0, timeout},   32'd0);

    // ld_valid across reset release and in IDLE must be ignored
    ld_valid = 1'b1; ld_data = 8'h99; reset = 1'b0;
    tick(); tick();
    ld_valid = 1'b0;
    chk("idle_ld_ready", {31'd0, ld_ready}, 32'd0);

    // partial word then reset: discarded
    start = 1'b1; tick(); start = 1'b0;
    chk("load_ld_ready", {31'd0, ld_ready}, 32'd1);
    send_byte(8'h78); send_byte(8'h56);
    reset = 1'b1; tick(); tick();
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_ld_ready",  {31'd0, ld_ready},  32'd0);
    reset = 1'b0; tick();

    // contiguous load
    start = 1'b1; tick(); start = 1'b0;
    push_prog();
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    chk("last_write_ld_ready",  {31'd0, ld_ready},  32'd0);
    chk("last_write_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    wait_run("run_entry_1");
    chk("imem_all_written", imem_q.size(), 32'd0);

    // PC match
    cpu_pc = 32'h74; tick(); tick();
    chk("run_no_match", {31'd0, cpu_reset}, 32'd0);
    cpu_pc = 32'h78; push_dump(); tick();
    chk("dump_entry_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    cpu_pc = 32'h0;

    // dump with 1,0,0,1 backpressure
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      dmp_ready = rdy_pat[cyc % 4];
      tick();
      cyc++;
    end
    dmp_ready = 1'b0;
    chk("dump1_done",    {31'd0, done},    32'd1);
    chk("dump1_drained", dmp_q.size(),     32'd0);
    chk("dump1_timeout", {31'd0, timeout}, 32'd0);

    // restart from DONE with a gapped load
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done_clr", {31'd0, done},     32'd0);
    chk("restart_ld_ready", {31'd0, ld_ready}, 32'd1);
    push_prog();
    for (int i = 0; i < 8; i++) begin send_byte(prog[i]); tick(); end
    wait_run("run_entry_2");
    chk("imem_all_written_2", imem_q.size(), 32'd0);

`ifdef LOADER_WDOG_EN
    push_dump();
    cyc = 0;
    while (cpu_reset === 1'b0 && cyc < 100) begin tick(); cyc++; end
    chk("wdog_run_cycles", cyc, 32'd16);
    chk("wdog_timeout",    {31'd0, timeout}, 32'd1);
    drain_dump(cyc);
    chk("wdog_done",         {31'd0, done},    32'd1);
    chk("wdog_timeout_hold", {31'd0, timeout}, 32'd1);
    chk("wdog_drained",      dmp_q.size(),     32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("wdog_timeout_clr", {31'd0, timeout}, 32'd0);
`else
    cpu_pc = 32'h78; push_dump(); tick(); cpu_pc = 32'h0;
    drain_dump(cyc);
    // entry cycle fetches nothing, then 96 captures, then the final accept
    chk("dump2_cycles",  cyc, 32'd97);
    chk("dump2_done",    {31'd0, done},    32'd1);
    chk("dump2_drained", dmp_q.size(),     32'd0);
    chk("dump2_timeout", {31'd0, timeout}, 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
